// File: rtl/pipe_ctrl_unit.sv
// ID-stage control unit for a 5-stage MIPS pipeline: decode into a registered
// ID/EX bundle, beq/j resolution, load-use stall and multi-cycle multiply sequencing.
module pipe_ctrl_unit #(
  parameter int ALUOP_W    = 2,
  parameter int MUL_CYCLES = 4,
  parameter int LU_DETECT  = 1,
  localparam int CTRL_W    = 7 + ALUOP_W
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              valid_i,
  input  logic [5:0]        Op_i,
  input  logic [5:0]        Funct_i,
  input  logic [4:0]        Rs_i,
  input  logic [4:0]        Rt_i,
  input  logic              Equal_i,
  input  logic              IDEX_MemRead_i,
  input  logic [4:0]        IDEX_Rt_i,
  output logic [CTRL_W-1:0] ctrl_o,
  output logic              stall_o,
  output logic              flush_o,
  output logic              Branch_o,
  output logic              Jump_o,
  output logic              mul_busy_o,
  output logic              illegal_o
);

  localparam logic [0:0] ST_RUN = 1'b0;
  localparam logic [0:0] ST_MUL = 1'b1;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_J     = 6'b000010;
  localparam logic [5:0] FN_MULT  = 6'b011000;

  localparam logic [1:0] ALU_ADD   = 2'd0;
  localparam logic [1:0] ALU_SUB   = 2'd1;
  localparam logic [1:0] ALU_FUNCT = 2'd2;

  localparam logic       MUL_STALLS = (MUL_CYCLES > 1);
  localparam logic [7:0] CNT_INIT   = (MUL_CYCLES > 1) ? 8'(MUL_CYCLES - 2) : 8'd0;

  function automatic logic [CTRL_W-1:0] pack_ctrl(
    input logic       reg_write,
    input logic       mem_to_reg,
    input logic       mem_read,
    input logic       mem_write,
    input logic       alu_src,
    input logic [1:0] alu_op,
    input logic       reg_dst,
    input logic       mul_start
  );
    logic [CTRL_W-1:0] c;
    c               = '0;
    c[0]            = reg_write;
    c[1]            = mem_to_reg;
    c[2]            = mem_read;
    c[3]            = mem_write;
    c[4]            = alu_src;
    c[5 +: 2]       = alu_op;
    c[5 + ALUOP_W]  = reg_dst;
    c[6 + ALUOP_W]  = mul_start;
    return c;
  endfunction

  logic [0:0]        state_q, state_d;
  logic [7:0]        cnt_q, cnt_d;
  logic [CTRL_W-1:0] ctrl_q, ctrl_d;
  logic              illegal_q, illegal_d;

  logic [CTRL_W-1:0] dec_ctrl;
  logic              dec_illegal, is_beq, is_j, is_mult;
  logic              lu, in_mul, issue;

  always_comb begin
    dec_ctrl    = '0;
    dec_illegal = 1'b0;
    is_beq      = 1'b0;
    is_j        = 1'b0;
    is_mult     = 1'b0;
    case (Op_i)
      OP_RTYPE: begin
        if (Funct_i == FN_MULT) begin
          is_mult  = 1'b1;
          dec_ctrl = pack_ctrl(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, ALU_FUNCT, 1'b1, 1'b1);
        end else begin
          dec_ctrl = pack_ctrl(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, ALU_FUNCT, 1'b1, 1'b0);
        end
      end
      OP_ADDI: dec_ctrl = pack_ctrl(1'b1, 1'b0, 1'b0, 1'b0, 1'b1, ALU_ADD, 1'b0, 1'b0);
      OP_LW:   dec_ctrl = pack_ctrl(1'b1, 1'b1, 1'b1, 1'b0, 1'b1, ALU_ADD, 1'b0, 1'b0);
      OP_SW:   dec_ctrl = pack_ctrl(1'b0, 1'b0, 1'b0, 1'b1, 1'b1, ALU_ADD, 1'b0, 1'b0);
      OP_BEQ: begin
        is_beq   = 1'b1;
        dec_ctrl = pack_ctrl(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, ALU_SUB, 1'b0, 1'b0);
      end
      OP_J:    is_j = 1'b1;
      default: dec_illegal = 1'b1;
    endcase
  end

  // Hazard priority: reset, then an in-flight multiply, then load-use, then decode.
  assign lu = (LU_DETECT != 0) && valid_i && IDEX_MemRead_i && (IDEX_Rt_i != 5'd0) &&
              ((IDEX_Rt_i == Rs_i) || (IDEX_Rt_i == Rt_i));
  assign in_mul = (state_q == ST_MUL);
  assign issue  = !rst_i && valid_i && !in_mul && !lu;

  assign stall_o    = !rst_i && (in_mul || lu);
  assign mul_busy_o = !rst_i && in_mul;
  assign Branch_o   = issue && is_beq && Equal_i;
  assign Jump_o     = issue && is_j;
  assign flush_o    = Branch_o || Jump_o;

  assign ctrl_d    = issue ? dec_ctrl : '0;
  assign illegal_d = issue && dec_illegal;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    if (in_mul) begin
      if (cnt_q == 8'd0) state_d = ST_RUN;
      else               cnt_d   = cnt_q - 8'd1;
    end else if (issue && is_mult && MUL_STALLS) begin
      state_d = ST_MUL;
      cnt_d   = CNT_INIT;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q   <= ST_RUN;
      cnt_q     <= 8'd0;
      illegal_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      illegal_q <= illegal_d;
    end
    ctrl_q <= ctrl_d;
  end

  assign ctrl_o    = ctrl_q;
  assign illegal_o = illegal_q;

endmodule
